// File: rtl/stall_pkg.sv
// stall_pkg
//   Shared definitions for the hazard/stall controller: forward-mux
//   encodings, Tuse/Tnew constants, shadow pipeline stage records and
//   the per-source stall / forward decode helpers.
package stall_pkg;

    localparam int REG_W = 5;
    localparam int T_W   = 2;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [T_W-1:0] TUSE_NEVER = 2'd3;
    localparam logic [T_W-1:0] TNEW_JAL   = 2'd0;
    localparam logic [T_W-1:0] TNEW_CAL   = 2'd1;
    localparam logic [T_W-1:0] TNEW_LOAD  = 2'd2;

    // Instruction as seen while it sits in E.
    typedef struct packed {
        logic [REG_W-1:0] wa;
        logic [T_W-1:0]   tnew;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             md_start;
        logic             md_div;
    } shadow_e_t;

    // Instruction as seen while it sits in M (W only needs wa).
    typedef struct packed {
        logic [REG_W-1:0] wa;
        logic [T_W-1:0]   tnew;
    } shadow_m_t;

    function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // A producer still more than tuse cycles from its result blocks the consumer.
    function automatic logic src_stall(input logic [REG_W-1:0] src,
                                       input logic [T_W-1:0]   tuse,
                                       input shadow_e_t        e,
                                       input shadow_m_t        m);
        if (src == '0 || tuse == TUSE_NEVER)
            return 1'b0;
        return ((e.wa == src) && (e.tnew > tuse)) ||
               ((m.wa == src) && (m.tnew > tuse));
    endfunction

    function automatic logic [1:0] fwd_d_sel(input logic [REG_W-1:0] src,
                                             input shadow_e_t        e,
                                             input shadow_m_t        m,
                                             input logic [REG_W-1:0] w_wa);
        if (src == '0)                                 return FWD_RF;
        if ((e.wa == src) && (e.tnew == TNEW_JAL))     return FWD_E;
        if ((m.wa == src) && (m.tnew == TNEW_JAL))     return FWD_M;
        if (w_wa == src)                               return FWD_W;
        return FWD_RF;
    endfunction

    // E-stage consumer: an M producer still in flight is not a valid source.
    function automatic logic [1:0] fwd_e_sel(input logic [REG_W-1:0] src,
                                             input shadow_m_t        m,
                                             input logic [REG_W-1:0] w_wa);
        if (src == '0)                                 return FWD_RF;
        if ((m.wa == src) && (m.tnew == TNEW_JAL))     return FWD_M;
        if (w_wa == src)                               return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer
//   Down-counter tracking the multiply/divide unit occupancy.
//   Ports:
//     clk, reset_n  clock, async active-low reset
//     i_load        mult/div instruction is in E this cycle
//     i_div         selects DIV_CYC instead of MULT_CYC on load
//     o_busy        counter nonzero
module md_busy_timer #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_div,
    output logic o_busy
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Consumer-side hazard unit: compares D-stage source needs (Tuse)
//   against a shadow E/M/W pipeline of producers (Tnew) and decides
//   stall vs. forward. Also stalls HI/LO users while the MDU is busy.
//   Optional build macro STALL_PERF_EN adds stall-cause cycle counters.
//   Ports:
//     clk, reset_n              clock, async active-low reset
//     d_rs/d_rt, d_tuse_rs/rt   D-stage sources and their Tuse
//     d_wa, d_tnew              D-stage destination and its Tnew
//     d_md_start/div/use        mult/div start, div select, any HI/LO op
//     stall                     freeze PC/D, bubble into E
//     fwd_d_rs/rt, fwd_e_rs/rt  forward-mux selects (stall_pkg FWD_*)
//     md_busy                   MDU timer nonzero
//     perf_data_stalls/perf_md_stalls  (STALL_PERF_EN only)
module hazard_stall_ctrl
    import stall_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  d_wa,
    input  logic [1:0]  d_tnew,
    input  logic        d_md_start,
    input  logic        d_md_div,
    input  logic        d_md_use,
    output logic        stall,
    output logic [1:0]  fwd_d_rs,
    output logic [1:0]  fwd_d_rt,
    output logic [1:0]  fwd_e_rs,
    output logic [1:0]  fwd_e_rt,
    output logic        md_busy
`ifdef STALL_PERF_EN
    ,
    output logic [31:0] perf_data_stalls,
    output logic [31:0] perf_md_stalls
`endif
);

    shadow_e_t        r_e;
    shadow_m_t        r_m;
    logic [REG_W-1:0] r_w_wa;

    logic w_data_stall;
    logic w_md_stall;
    logic w_stall;
    logic w_md_busy;

    assign w_data_stall = src_stall(d_rs, d_tuse_rs, r_e, r_m) |
                          src_stall(d_rt, d_tuse_rt, r_e, r_m);
    // A mult/div sitting in E has not loaded the timer yet, so it blocks too.
    assign w_md_stall   = d_md_use & (w_md_busy | r_e.md_start);
    assign w_stall      = w_data_stall | w_md_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e    <= '0;
            r_m    <= '0;
            r_w_wa <= '0;
        end else begin
            r_w_wa <= r_m.wa;
            r_m    <= '{wa: r_e.wa, tnew: tnew_dec(r_e.tnew)};
            if (w_stall)
                r_e <= '0;
            else
                r_e <= '{wa: d_wa, tnew: d_tnew, rs: d_rs, rt: d_rt,
                         md_start: d_md_start, md_div: d_md_div};
        end
    end

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (r_e.md_start),
        .i_div   (r_e.md_div),
        .o_busy  (w_md_busy)
    );

    assign stall    = w_stall;
    assign md_busy  = w_md_busy;
    assign fwd_d_rs = fwd_d_sel(d_rs, r_e, r_m, r_w_wa);
    assign fwd_d_rt = fwd_d_sel(d_rt, r_e, r_m, r_w_wa);
    assign fwd_e_rs = fwd_e_sel(r_e.rs, r_m, r_w_wa);
    assign fwd_e_rt = fwd_e_sel(r_e.rt, r_m, r_w_wa);

`ifdef STALL_PERF_EN
    logic [31:0] r_perf_data;
    logic [31:0] r_perf_md;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_data <= '0;
            r_perf_md   <= '0;
        end else begin
            if (w_data_stall) r_perf_data <= r_perf_data + 32'd1;
            if (w_md_stall)   r_perf_md   <= r_perf_md + 32'd1;
        end
    end

    assign perf_data_stalls = r_perf_data;
    assign perf_md_stalls   = r_perf_md;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl (default parameters).
module tb_hazard_stall_ctrl;
    import stall_pkg::*;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       stall, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
`ifdef STALL_PERF_EN
    logic [31:0] perf_data_stalls, perf_md_stalls;
`endif

    int n_vec = 0;
    int n_err = 0;

    hazard_stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_wa       (d_wa),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .stall      (stall),
        .fwd_d_rs   (fwd_d_rs),
        .fwd_d_rt   (fwd_d_rt),
        .fwd_e_rs   (fwd_e_rs),
        .fwd_e_rt   (fwd_e_rt),
        .md_busy    (md_busy)
`ifdef STALL_PERF_EN
        ,
        .perf_data_stalls (perf_data_stalls),
        .perf_md_stalls   (perf_md_stalls)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [1:0] tr,
                         input logic [4:0] rt, input logic [1:0] tt,
                         input logic [4:0] wa, input logic [1:0] tn,
                         input logic ms, input logic md, input logic mu);
        d_rs = rs; d_tuse_rs = tr; d_rt = rt; d_tuse_rt = tt;
        d_wa = wa; d_tnew = tn;
        d_md_start = ms; d_md_div = md; d_md_use = mu;
    endtask

    task automatic nop();
        set_d(5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd0, TNEW_JAL, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    // lw $t0 -> add $t1,$t0,$t2 (one load-use bubble) -> sub $t3,$t1
    task automatic run_case1();
        set_d(5'd29, 2'd1, 5'd0, TUSE_NEVER, 5'd8, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("c1_lw_nostall", stall, 0);
        tick();
        set_d(5'd8, 2'd1, 5'd10, 2'd1, 5'd9, TNEW_CAL, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("c1_stall", stall, 1);
        chk("c1_fwd_d_rs_pending", fwd_d_rs, 0);
        tick();
        @(negedge clk); chk("c1_release", stall, 0);
        tick();
        set_d(5'd9, 2'd1, 5'd0, TUSE_NEVER, 5'd11, TNEW_CAL, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("c1_fwd_e_rs_w", fwd_e_rs, 3);
        chk("c1_fwd_e_rt_none", fwd_e_rt, 0);
        chk("c1_sub_nostall", stall, 0);
        tick();
        nop();
        @(negedge clk); chk("c1_fwd_e_rs_m", fwd_e_rs, 2);
        tick();
    endtask

    // mult/div then mflo held in D; count stall run and busy cycles.
    task automatic run_md(input logic is_div, input int exp_busy);
        int st = 0;
        int bz = 0;
        bit released = 0;
        set_d(5'd8, 2'd1, 5'd9, 2'd1, 5'd0, TNEW_JAL, 1'b1, is_div, 1'b1);
        @(negedge clk); chk("md_issue_nostall", stall, 0);
        tick();
        set_d(5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd10, TNEW_CAL, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_busy) bz++;
            if (!released) begin
                if (stall) st++;
                else released = 1;
            end
            tick();
        end
        chk(is_div ? "div_stall_cycles" : "mult_stall_cycles", st, exp_busy + 1);
        chk(is_div ? "div_busy_cycles" : "mult_busy_cycles", bz, exp_busy);
        nop();
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        nop();
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_md_busy", md_busy, 0);
        chk("rst_fwd_d", {fwd_d_rs, fwd_d_rt}, 0);
        chk("rst_fwd_e", {fwd_e_rs, fwd_e_rt}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        run_case1();

        // addu $t0 ; addu $t0 ; beq $t0 (tuse 0)
        set_d(5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd8, TNEW_CAL, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        set_d(5'd8, 2'd0, 5'd0, 2'd0, 5'd0, TNEW_JAL, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("c2_stall_e_tnew1", stall, 1);
        tick();
        @(negedge clk); chk("c2_nostall", stall, 0);
        chk("c2_fwd_d_rs_m_over_w", fwd_d_rs, 2);
        chk("c2_fwd_d_rt_zero", fwd_d_rt, 0);
        tick();

        // jal ; jr $ra
        set_d(5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd31, TNEW_JAL, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd31, 2'd0, 5'd0, TUSE_NEVER, 5'd0, TNEW_JAL, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("c3_fwd_d_e", fwd_d_rs, 1);
        chk("c3_nostall", stall, 0);
        tick();
        @(negedge clk); chk("c3_fwd_d_m", fwd_d_rs, 2);
        tick();
        @(negedge clk); chk("c3_fwd_d_w", fwd_d_rs, 3);
        set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, TNEW_JAL, 1'b0, 1'b0, 1'b0);
        #1;
        chk("c3_src0_fwd", {fwd_d_rs, fwd_d_rt}, 0);
        chk("c3_src0_nostall", stall, 0);
        nop();
        tick(); tick(); tick();

        run_md(1'b1, DIV_CYC);
        tick(); tick();
        run_md(1'b0, MULT_CYC);
        tick(); tick();

        // div ; lw $t0 ; consumer of $t0 that is also a HI/LO op
        set_d(5'd8, 2'd1, 5'd9, 2'd1, 5'd0, TNEW_JAL, 1'b1, 1'b1, 1'b1);
        tick();
        set_d(5'd29, 2'd1, 5'd0, TUSE_NEVER, 5'd8, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd8, 2'd1, 5'd0, TUSE_NEVER, 5'd9, TNEW_CAL, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk("c5_stall_pre", stall, 1);
        chk("c5_busy_pre", md_busy, 1);
        reset_n = 1'b0;
        #1;
        chk("c5_rst_stall", stall, 0);
        chk("c5_rst_busy", md_busy, 0);
        chk("c5_rst_fwd", {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt}, 0);
        #1;
        reset_n = 1'b1;
        set_d(5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd10, TNEW_CAL, 1'b0, 1'b0, 1'b1);
        #1;
        chk("c5_mflo_nostall", stall, 0);
        tick();
        @(negedge clk); chk("c5_busy_after", md_busy, 0);
        nop();
        tick();

`ifdef STALL_PERF_EN
        do_reset();
        chk("perf_rst_data", perf_data_stalls, 0);
        chk("perf_rst_md", perf_md_stalls, 0);
        run_case1();
        tick(); tick();
        run_md(1'b1, DIV_CYC);
        @(negedge clk);
        chk("perf_data_stalls", perf_data_stalls, 1);
        chk("perf_md_stalls", perf_md_stalls, DIV_CYC + 1);
`else
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
